reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised reset controller for Lexington SoC board tops. Synchronises and debounces the raw reset button, gates on MMCM lock, and holds reset for a fixed interval. It then releases NUM_RST active-low reset domains in order: channel 0 first, e.g. interconnect, then core. It also supports a core-initiated software reset and reports the cause of the last reset. It sits between the MMCM/board pins and the `lexington_soc` reset inputs.

## Interface
- NUM_RST, 2: number of sequenced reset outputs (>=1)
- SYNC_STAGES, 2: synchroniser depth for btn_rst and pll_locked (>=2)
- DEBOUNCE_CYCLES, 40000: cycles the synchronised button must be stable before it is accepted (>=1)
- HOLD_CYCLES, 16: cycles reset is held after lock and button release (>=1)
- STAGE_GAP, 4: cycles between consecutive channel releases (>=1)

Ports:
- clk, input, 1: core clock (MMCM output)
- rst_n, input, 1: reset; one clock; reset is asynchronous and active-low
- btn_rst, input, 1: raw, asynchronous, active-high button
- pll_locked, input, 1: asynchronous MMCM LOCKED
- sw_rst_req, input, 1: single-cycle synchronous software reset request from the core
- rst_n_out, output, NUM_RST: sequenced active-low resets; all are registered
- busy, output, 1: 1 whenever any rst_n_out bit is 0
- rst_cause, output, 2: cause of the last reset. 0 is power-on/rst_n, 1 is button, 2 is lock loss, 3 is software.

## Operation
- Async reset (rst_n=0) sets:
  - rst_n_out to all 0, busy to 1, rst_cause to 0
  - state to WAIT_LOCK
  - synchronisers, btn_db and all counters to 0
- Synchronisers: btn_rst and pll_locked each pass through SYNC_STAGES flops, giving btn_s and lock_s.
- Debounce:
  - The counter increments while btn_s != btn_db and clears to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, btn_db takes btn_s and the counter clears.
  - A "button trigger" is a 0->1 change of btn_db.
- FSM states:
  - WAIT_LOCK:
    - All outputs are 0.
    - When lock_s=1 and btn_db=0, go to HOLD and clear the count.
  - HOLD:
    - The counter runs.
    - If lock_s=0 or btn_db=1, return to WAIT_LOCK.
    - When the count reaches HOLD_CYCLES-1, go to RELEASE. On that same edge, set rst_n_out[0]=1 and clear stage and gap.
  - RELEASE:
    - Every STAGE_GAP cycles, set the next channel's bit to 1.
    - On the edge that raises rst_n_out[NUM_RST-1], go to RUN and drop busy to 0.
    - If NUM_RST=1, HOLD goes directly to RUN.
  - RUN:
    - Steady state.
    - On a trigger, all rst_n_out go to 0 and busy goes to 1 on the next edge. rst_cause is written and the state goes to WAIT_LOCK.
- Triggers and priority when simultaneous: lock loss (lock_s=0) > button trigger > sw_rst_req.
  - In HOLD and RELEASE, lock loss and btn_db=1 abort to WAIT_LOCK. All channels already released are re-asserted, and rst_cause is updated (2 or 1).
  - sw_rst_req is ignored outside RUN.
- Released bits stay 1 until a trigger occurs. There is no partial re-assert: every trigger clears all bits together.
- Counters are sized $clog2(max(value,2)) bits. Compare against value-1 with no wrap; a counter saturates and clears only on a state change.

## Timing
- Edges are counted from the first rising edge after rst_n deasserts (edge 1), with pll_locked=1 and btn_rst=0 held throughout.
  - lock_s=1 at edge SYNC_STAGES.
  - HOLD is entered at edge SYNC_STAGES+1.
  - T0 = SYNC_STAGES+1+HOLD_CYCLES. rst_n_out[k] rises at edge T0+k*STAGE_GAP.
  - busy falls at edge T0+(NUM_RST-1)*STAGE_GAP.
  - With the defaults: rst_n_out[0] rises at edge 19 and rst_n_out[1] at edge 23.
- sw_rst_req sampled high in RUN at edge E:
  - rst_n_out is all 0 at E, busy=1, rst_cause=3.
  - The lock is still high, so HOLD is entered at E+1 and the release sequence repeats from there.
- Lock loss: pll_locked falls, and all outputs are 0 at most SYNC_STAGES+1 edges later.
- Button: a press held for DEBOUNCE_CYCLES produces outputs of 0 SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after the press. The sequence restarts only after the debounced release.
- Glitches shorter than DEBOUNCE_CYCLES on btn_s have no effect.

## Test plan
- Power-on with defaults and NUM_RST=3 -> rst_n_out bits rise at edges 19, 23 and 27. busy falls at edge 27, rst_cause=0.
- In RUN, pulse sw_rst_req for 1 cycle -> all bits are 0 on the next edge with rst_cause=3. Release re-occurs HOLD_CYCLES+1 edges later, channels 4 cycles apart.
- DEBOUNCE_CYCLES=8. A 5-cycle button glitch leaves outputs unchanged. A 20-cycle press gives outputs 0 and rst_cause=1, and the release sequence starts only after the button has been low for 8 cycles.
- Drop pll_locked during RELEASE after channel 0 is released -> channel 0 is re-asserted within 3 edges and rst_cause=2. The bench then verifies that no channel releases until the lock returns.
- In RUN, lock loss, button trigger and sw_rst_req in the same cycle -> rst_cause=2. sw_rst_req asserted during HOLD -> ignored.
- Assert rst_n mid-RELEASE -> outputs are immediately (asynchronously) all 0, busy=1, rst_cause=0.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: board-level reset controller. Synchronises and debounces
// the reset button, waits for MMCM lock, holds reset for a fixed interval and
// then releases NUM_RST active-low reset domains one after another (channel 0
// first). A core-initiated software reset is supported and the cause of the
// most recent reset is reported on rst_cause.
module reset_sequencer #(
  parameter int NUM_RST         = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 40000,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_rst,
  input  logic               pll_locked,
  input  logic               sw_rst_req,
  output logic [NUM_RST-1:0] rst_n_out,
  output logic               busy,
  output logic [1:0]         rst_cause
);

  // Counter widths: each counter only has to reach (value-1); a floor of 2
  // keeps every counter at least one bit wide.
  localparam int DB_W    = $clog2((DEBOUNCE_CYCLES > 2) ? DEBOUNCE_CYCLES : 2);
  localparam int HOLD_W  = $clog2((HOLD_CYCLES > 2) ? HOLD_CYCLES : 2);
  localparam int GAP_W   = $clog2((STAGE_GAP > 2) ? STAGE_GAP : 2);
  localparam int STAGE_W = $clog2((NUM_RST > 2) ? NUM_RST : 2);

  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(STAGE_GAP - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_RST - 1);

  // Encodings reported on rst_cause.
  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_BTN  = 2'd1;
  localparam logic [1:0] CAUSE_LOCK = 2'd2;
  localparam logic [1:0] CAUSE_SW   = 2'd3;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    RELEASE,
    RUN
  } state_t;

  // Synchroniser chains and their outputs.
  logic [SYNC_STAGES-1:0] btn_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   btn_s;
  logic                   lock_s;

  // Debounce state.
  logic [DB_W-1:0] db_cnt;
  logic            btn_db;
  logic            btn_db_q;
  logic            btn_trig;

  // Sequencer state.
  state_t              state;
  state_t              state_nx;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_nx;
  logic [GAP_W-1:0]    gap_cnt;
  logic [GAP_W-1:0]    gap_nx;
  logic [STAGE_W-1:0]  stage;
  logic [STAGE_W-1:0]  stage_nx;
  logic [STAGE_W-1:0]  stage_inc;
  logic [NUM_RST-1:0]  out_nx;
  logic                busy_nx;
  logic [1:0]          cause_nx;

  assign btn_s     = btn_sync[SYNC_STAGES-1];
  assign lock_s    = lock_sync[SYNC_STAGES-1];
  assign btn_trig  = btn_db & ~btn_db_q;
  assign stage_inc = stage + 1'b1;

  // Bring the asynchronous button and lock inputs into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync  <= '0;
      lock_sync <= '0;
    end else begin
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_rst};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Accept a new button level only after it has differed from the accepted
  // level for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Sequencer register: state, counters and the registered reset outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      stage     <= '0;
      rst_n_out <= '0;
      busy      <= 1'b1;
      rst_cause <= CAUSE_POR;
    end else begin
      state     <= state_nx;
      hold_cnt  <= hold_nx;
      gap_cnt   <= gap_nx;
      stage     <= stage_nx;
      rst_n_out <= out_nx;
      busy      <= busy_nx;
      rst_cause <= cause_nx;
    end
  end

  // Next-state logic: lock loss outranks the button, which outranks the
  // software request; any reset event drops every channel at once.
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    gap_nx   = gap_cnt;
    stage_nx = stage;
    out_nx   = rst_n_out;
    cause_nx = rst_cause;

    case (state)
      WAIT_LOCK: begin
        out_nx = '0;
        if (lock_s && !btn_db) begin
          state_nx = HOLD;
          hold_nx  = '0;
          gap_nx   = '0;
          stage_nx = '0;
        end
      end

      HOLD: begin
        if (!lock_s || btn_db) begin
          state_nx = WAIT_LOCK;
          out_nx   = '0;
          cause_nx = !lock_s ? CAUSE_LOCK : CAUSE_BTN;
          hold_nx  = '0;
          gap_nx   = '0;
          stage_nx = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          out_nx[0] = 1'b1;
          gap_nx    = '0;
          stage_nx  = '0;
          hold_nx   = '0;
          state_nx  = (NUM_RST == 1) ? RUN : RELEASE;
        end else begin
          hold_nx = hold_cnt + 1'b1;
        end
      end

      RELEASE: begin
        if (!lock_s || btn_db) begin
          state_nx = WAIT_LOCK;
          out_nx   = '0;
          cause_nx = !lock_s ? CAUSE_LOCK : CAUSE_BTN;
          hold_nx  = '0;
          gap_nx   = '0;
          stage_nx = '0;
        end else if (gap_cnt == GAP_LAST) begin
          for (int k = 1; k < NUM_RST; k++) begin
            if (STAGE_W'(k) == stage_inc) begin
              out_nx[k] = 1'b1;
            end
          end
          gap_nx   = '0;
          stage_nx = stage_inc;
          if (stage_inc == STAGE_LAST) begin
            state_nx = RUN;
            stage_nx = '0;
          end
        end else begin
          gap_nx = gap_cnt + 1'b1;
        end
      end

      RUN: begin
        if (!lock_s || btn_trig || sw_rst_req) begin
          state_nx = WAIT_LOCK;
          out_nx   = '0;
          hold_nx  = '0;
          gap_nx   = '0;
          stage_nx = '0;
          if (!lock_s) begin
            cause_nx = CAUSE_LOCK;
          end else if (btn_trig) begin
            cause_nx = CAUSE_BTN;
          end else begin
            cause_nx = CAUSE_SW;
          end
        end
      end

      default: begin
        state_nx = WAIT_LOCK;
        out_nx   = '0;
        hold_nx  = '0;
        gap_nx   = '0;
        stage_nx = '0;
      end
    endcase

    busy_nx = ~(&out_nx);
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed bench for reset_sequencer with three channels
// and a short debounce so the button scenarios stay brief.
module tb_reset_sequencer;

  localparam int NUM_RST         = 3;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 8;
  localparam int HOLD_CYCLES     = 16;
  localparam int STAGE_GAP       = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               btn_rst;
  logic               pll_locked;
  logic               sw_rst_req;
  logic [NUM_RST-1:0] rst_n_out;
  logic               busy;
  logic [1:0]         rst_cause;

  int checks   = 0;
  int errors   = 0;
  int edge_num = 0;

  reset_sequencer #(
    .NUM_RST(NUM_RST),
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .STAGE_GAP(STAGE_GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_rst(btn_rst),
    .pll_locked(pll_locked),
    .sw_rst_req(sw_rst_req),
    .rst_n_out(rst_n_out),
    .busy(busy),
    .rst_cause(rst_cause)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic btn, input logic lock, input logic sw);
    btn_rst    = btn;
    pll_locked = lock;
    sw_rst_req = sw;
  endtask

  // Advance to just after rising edge number 'target' (edge 1 is the first
  // rising edge after rst_n deasserts).
  task automatic advance_to(input int target);
    while (edge_num < target) begin
      @(posedge clk);
      #1;
      edge_num++;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Directed sequence with hand-computed edge numbers.
  initial begin
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("por_out", rst_n_out, 3'b000);
    check_output("por_busy", busy, 1'b1);
    check_output("por_cause", rst_cause, 2'd0);
    rst_n = 1'b1;

    $display("[TB] power-on release sequence");
    advance_to(18); check_output("e18_out", rst_n_out, 3'b000);
    advance_to(19); check_output("e19_out", rst_n_out, 3'b001);
    check_output("e19_busy", busy, 1'b1);
    advance_to(22); check_output("e22_out", rst_n_out, 3'b001);
    advance_to(23); check_output("e23_out", rst_n_out, 3'b011);
    advance_to(26); check_output("e26_out", rst_n_out, 3'b011);
    check_output("e26_busy", busy, 1'b1);
    advance_to(27); check_output("e27_out", rst_n_out, 3'b111);
    check_output("e27_busy", busy, 1'b0);
    check_output("e27_cause", rst_cause, 2'd0);

    $display("[TB] software reset, then request ignored during hold");
    advance_to(29); apply_stimulus(1'b0, 1'b1, 1'b1);
    advance_to(30); apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("sw_out", rst_n_out, 3'b000);
    check_output("sw_busy", busy, 1'b1);
    check_output("sw_cause", rst_cause, 2'd3);
    advance_to(34); apply_stimulus(1'b0, 1'b1, 1'b1);
    advance_to(35); apply_stimulus(1'b0, 1'b1, 1'b0);
    advance_to(46); check_output("sw_e46_out", rst_n_out, 3'b000);
    advance_to(47); check_output("sw_e47_out", rst_n_out, 3'b001);

    $display("[TB] lock loss during release");
    advance_to(48); apply_stimulus(1'b0, 1'b0, 1'b0);
    advance_to(50); check_output("ll_e50_out", rst_n_out, 3'b001);
    advance_to(51); check_output("ll_e51_out", rst_n_out, 3'b000);
    check_output("ll_cause", rst_cause, 2'd2);
    check_output("ll_busy", busy, 1'b1);
    advance_to(70); check_output("ll_e70_out", rst_n_out, 3'b000);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    advance_to(88); check_output("ll_e88_out", rst_n_out, 3'b000);
    advance_to(89); check_output("ll_e89_out", rst_n_out, 3'b001);
    advance_to(93); check_output("ll_e93_out", rst_n_out, 3'b011);
    advance_to(97); check_output("ll_e97_out", rst_n_out, 3'b111);
    check_output("ll_e97_busy", busy, 1'b0);

    $display("[TB] short button glitch");
    advance_to(100); apply_stimulus(1'b1, 1'b1, 1'b0);
    advance_to(105); apply_stimulus(1'b0, 1'b1, 1'b0);
    advance_to(120); check_output("gl_out", rst_n_out, 3'b111);
    check_output("gl_busy", busy, 1'b0);
    check_output("gl_cause", rst_cause, 2'd2);

    $display("[TB] debounced button press");
    apply_stimulus(1'b1, 1'b1, 1'b0);
    advance_to(130); check_output("bt_e130_out", rst_n_out, 3'b111);
    advance_to(131); check_output("bt_e131_out", rst_n_out, 3'b000);
    check_output("bt_cause", rst_cause, 2'd1);
    check_output("bt_busy", busy, 1'b1);
    advance_to(140); apply_stimulus(1'b0, 1'b1, 1'b0);
    advance_to(166); check_output("bt_e166_out", rst_n_out, 3'b000);
    advance_to(167); check_output("bt_e167_out", rst_n_out, 3'b001);
    advance_to(171); check_output("bt_e171_out", rst_n_out, 3'b011);
    advance_to(175); check_output("bt_e175_out", rst_n_out, 3'b111);

    $display("[TB] simultaneous lock loss, button and software request");
    advance_to(179); apply_stimulus(1'b1, 1'b1, 1'b0);
    advance_to(187); apply_stimulus(1'b1, 1'b0, 1'b0);
    advance_to(189); apply_stimulus(1'b1, 1'b0, 1'b1);
    check_output("pr_e189_out", rst_n_out, 3'b111);
    advance_to(190); apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("pr_out", rst_n_out, 3'b000);
    check_output("pr_cause", rst_cause, 2'd2);
    advance_to(216); check_output("pr_e216_out", rst_n_out, 3'b000);
    advance_to(217); check_output("pr_e217_out", rst_n_out, 3'b001);
    advance_to(221); check_output("pr_e221_out", rst_n_out, 3'b011);

    $display("[TB] asynchronous reset mid-release");
    #2;
    rst_n = 1'b0;
    #1;
    check_output("ar_out", rst_n_out, 3'b000);
    check_output("ar_busy", busy, 1'b1);
    check_output("ar_cause", rst_cause, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
